sap_1_sequencer: RTL and testbench

// - SAP-1 controller front end: 6-state T-state ring counter plus instruction decoder.
// - Feeds the control matrix directly: ring_counter[6:1] (one-hot T1..T6) and decoded LDA/ADD/SUB/OUT.
// - Owns HLT. Freezes the machine in T4 on a halt instruction until CLR.
// - Opcode input is the IR upper nibble. IR loads at the end of T3, so the opcode is valid from T4 to T6.

---
 rtl/sap_1_sequencer.sv | 71 +++++++
 tb/tb_sap_1_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sap_1_sequencer.sv
// SAP-1 controller front end: one-hot T1..T6 ring counter, opcode decode, HLT ownership.
// Ring/HLT are registered (1 edge); decode is combinational (0 latency). No backpressure.
// Optional SAP_1_SINGLE_STEP_EN adds a STEP input and advances one T-state per STEP rise.
module sap_1_sequencer #(
  parameter logic [3:0] OPCODE_LDA = 4'b0000,
  parameter logic [3:0] OPCODE_ADD = 4'b0001,
  parameter logic [3:0] OPCODE_SUB = 4'b0010,
  parameter logic [3:0] OPCODE_OUT = 4'b1110,
  parameter logic [3:0] OPCODE_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR,
`ifdef SAP_1_SINGLE_STEP_EN
  input  logic       STEP,
`endif
  input  logic [3:0] opcode,
  output logic [6:1] ring_counter,
  output logic       LDA,
  output logic       ADD,
  output logic       SUB,
  output logic       OUT,
  output logic       HLT
);

  localparam logic [6:1] T1 = 6'b000001;
  localparam logic [6:1] T4 = 6'b001000;

  if (OPCODE_LDA == OPCODE_ADD || OPCODE_LDA == OPCODE_SUB || OPCODE_LDA == OPCODE_OUT ||
      OPCODE_LDA == OPCODE_HLT || OPCODE_ADD == OPCODE_SUB || OPCODE_ADD == OPCODE_OUT ||
      OPCODE_ADD == OPCODE_HLT || OPCODE_SUB == OPCODE_OUT || OPCODE_SUB == OPCODE_HLT ||
      OPCODE_OUT == OPCODE_HLT) begin : g_opcode_clash
    $error("sap_1_sequencer: opcode parameters must be pairwise distinct");
  end

  logic adv;
  logic ring_legal;

`ifdef SAP_1_SINGLE_STEP_EN
  logic step_d;

  always_ff @(posedge CLK) begin
    if (CLR) step_d <= 1'b0;
    else     step_d <= STEP;
  end

  assign adv = STEP && !step_d;
`else
  assign adv = 1'b1;
`endif

  assign ring_legal = (ring_counter != '0) && ((ring_counter & (ring_counter - 6'd1)) == '0);

  // An illegal ring recovers to T1 even while halted; HLT itself only clears on CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring_counter <= T1;
      HLT          <= 1'b0;
    end else if (!ring_legal) begin
      ring_counter <= T1;
    end else if (!HLT && adv) begin
      if (ring_counter == T4 && opcode == OPCODE_HLT) HLT <= 1'b1;
      else ring_counter <= {ring_counter[5:1], ring_counter[6]};
    end
  end

  assign LDA = (opcode == OPCODE_LDA);
  assign ADD = (opcode == OPCODE_ADD);
  assign SUB = (opcode == OPCODE_SUB);
  assign OUT = (opcode == OPCODE_OUT);

endmodule

// File: tb/tb_sap_1_sequencer.sv
// Scoreboard bench for sap_1_sequencer: integer T-state reference model, queue-decoupled monitor.
module tb_sap_1_sequencer;

  typedef struct {
    logic [5:0] ring;
    logic       hlt;
    logic [3:0] dec;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] opcode = 4'b0000;
`ifdef SAP_1_SINGLE_STEP_EN
  logic       STEP = 1'b0;
  bit         m_step_d = 1'b0;
`endif
  logic [6:1] ring_counter;
  logic       LDA, ADD, SUB, OUT, HLT;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   m_t     = 1;     // 1..6 = T-state index, 0 = forced illegal ring
  bit   m_hlt   = 1'b0;

  sap_1_sequencer dut (
    .CLK          (CLK),
    .CLR          (CLR),
`ifdef SAP_1_SINGLE_STEP_EN
    .STEP         (STEP),
`endif
    .opcode       (opcode),
    .ring_counter (ring_counter),
    .LDA          (LDA),
    .ADD          (ADD),
    .SUB          (SUB),
    .OUT          (OUT),
    .HLT          (HLT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: samples 1 time unit after each rising edge, once per pushed expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ring_counter", {2'b00, ring_counter}, {2'b00, e.ring});
        check("HLT", {7'd0, HLT}, {7'd0, e.hlt});
        check("decode", {4'd0, LDA, ADD, SUB, OUT}, {4'd0, e.dec});
      end
    end
  end

  task automatic step(input bit clr, input logic [3:0] op, input bit stp, input bit frc);
    exp_t e;
    bit   adv;
    @(negedge CLK);
    if (frc) begin
      force dut.ring_counter = 6'b000110;
      #1;
      release dut.ring_counter;
      m_t = 0;
    end
    CLR    = clr;
    opcode = op;
`ifdef SAP_1_SINGLE_STEP_EN
    STEP = stp;
`endif
    if (clr) begin
      m_t   = 1;
      m_hlt = 1'b0;
`ifdef SAP_1_SINGLE_STEP_EN
      m_step_d = 1'b0;
`endif
    end else begin
`ifdef SAP_1_SINGLE_STEP_EN
      adv      = stp && !m_step_d;
      m_step_d = stp;
`else
      adv = 1'b1;
`endif
      if (m_t == 0) m_t = 1;
      else if (!m_hlt && adv) begin
        if (m_t == 4 && op == 4'hF) m_hlt = 1'b1;
        else m_t = (m_t == 6) ? 1 : m_t + 1;
      end
    end
    e.ring = 6'(1 << (m_t - 1));
    e.hlt  = m_hlt;
    e.dec  = {op == 4'd0, op == 4'd1, op == 4'd2, op == 4'd14};
    @(posedge CLK);
    sb.push_back(e);
  endtask

  // Runs (toggling STEP so single-step builds also move) until the model sits at target.
  task automatic run_to(input int target, input logic [3:0] op);
    bit s = 1'b0;
    for (int k = 0; k < 100 && m_t != target; k++) begin
      s = !s;
      step(1'b0, op, s, 1'b0);
    end
    if (m_t != target) $display("FAIL run_to: model stuck at T%0d wanted T%0d", m_t, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    // Reset then free run with LDA.
    step(1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Decode sweep, held in reset so the ring stays put.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b0);

    // Halt at T4, hold 20 edges, change opcode, then CLR.
    step(1'b1, 4'd0, 1'b0, 1'b0);
    run_to(4, 4'd0);
    step(1'b0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 4'hF, i[0], 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd1, i[0], 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);

    // Late halt: HLT opcode only in T5/T6 must not halt.
    run_to(5, 4'd0);
    step(1'b0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
    step(1'b0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
    run_to(1, 4'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // Mid-op reset at T5 during ADD, then illegal-ring recovery.
    run_to(5, 4'd1);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    run_to(3, 4'd1);
    step(1'b0, 4'd2, 1'b0, 1'b1);
    step(1'b0, 4'd2, 1'b1, 1'b0);
    // Illegal ring while halted.
    step(1'b1, 4'd0, 1'b0, 1'b0);
    run_to(4, 4'd0);
    step(1'b0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
    step(1'b0, 4'hF, 1'b0, 1'b1);
    step(1'b0, 4'hF, 1'b0, 1'b0);

`ifdef SAP_1_SINGLE_STEP_EN
    // Three held STEP pulses advance one state each; STEP low holds.
    step(1'b1, 4'd0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
`endif

    // Randomized run, biased toward real opcodes and occasional CLR.
    step(1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'd14;
        4: op = 4'd15;
        default: op = 4'($urandom_range(0, 15));
      endcase
      step($urandom_range(0, 39) == 0, op, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    repeat (3) @(posedge CLK);
    #2;
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
